lsu: RTL
========

# lsu

Load/store unit sitting directly upstream of the byte-addressed data `memory` (32-bit words, M-bit word index, one-cycle registered read, masked write). It accepts one RISC-V load/store request at a time over a valid/ready handshake, drives the memory's address/mask/write-flag/write-data ports, and returns sign- or zero-extended load data. It also converts between the core's little-endian registers and the memory's big-endian byte order, where `ram[a]` maps to bits [31:24].

## Interface
- `M`, default 10: memory word-index width; memory spans 4·2^M bytes; byte address width is M+2.
- `clk` in 1: the block's one clock; every register updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3.
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other code is illegal.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, little-endian register value.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out 32: load result; 0 for stores and errors.
- `resp_err` out 1: request rejected; memory untouched.
- `mem_address` out M+2: to memory `address`.
- `mem_mask` out 32: to memory `mask`.
- `mem_wf` out 1: to memory `wf`.
- `mem_w` out 32: to memory `w`.
- `mem_v` in 32: from memory `v`.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`: latch the request and set `mem_address = req_addr[M+1:0]`.
  - Legal store: `mem_wf` = 1; go to ISSUE.
  - Legal load: `mem_wf` = 0; go to ISSUE.
  - Error: go to RESP with `resp_err` = 1.
- **Error conditions:**
  - Illegal funct3.
  - `req_addr` > 4·2^M − 4. The memory always touches 4 bytes, so this applies to byte accesses too.
  - With `LSU_MISALIGN_TRAP_EN`, misalignment (see Configuration).
- **ISSUE**
  - The memory samples its inputs at the edge ending ISSUE.
  - Store: `mem_wf` clears at that edge; go to RESP.
  - Load: go to CAPTURE.
- **CAPTURE**
  - `mem_v` is valid. Extract the result into the `resp_rdata` register; go to RESP.
- **RESP**
  - `resp_valid` = 1. `resp_rdata` and `resp_err` are held stable.
  - Leave to IDLE on `resp_ready`, after which both clear to 0.
- **Store encoding** (d = `req_wdata`):
  - sb: mask FF000000, w = {d[7:0],24'h0}.
  - sh: mask FFFF0000, w = {d[7:0],d[15:8],16'h0}.
  - sw: mask FFFFFFFF, w = {d[7:0],d[15:8],d[23:16],d[31:24]}.
- **Load extraction** (v = `mem_v`):
  - lb/lbu: v[31:24], sign/zero-extended.
  - lh/lhu: {v[23:16],v[31:24]}, sign/zero-extended.
  - lw: {v[7:0],v[15:8],v[23:16],v[31:24]}.
- `mem_mask` and `mem_w` are 0 for loads. All `mem_*` outputs are registered and hold their values until the next accept.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_wf`=0, `mem_address`=0, `mem_mask`=0, `mem_w`=0.
- Latency from the accepting edge to `resp_valid` high:
  - Load: 3 cycles.
  - Store: 2 cycles.
  - Error: 1 cycle.
- Throughput: at most one request in flight; the next accept is no earlier than the cycle after the RESP handshake.
- `mem_wf` is high for exactly one cycle (ISSUE) per legal store and is never high otherwise.
- `resp_ready` held high: the response lasts one cycle.
- `resp_ready` low: the response is held indefinitely; `mem_v` drift does not matter because the data was captured in CAPTURE.
- Reset asserted mid-operation: all state and outputs clear asynchronously.
  - `mem_wf` drops before the next edge, so an in-flight store is not written.
  - No response is produced for the aborted request.
- `req_valid` while not in IDLE: ignored; the requester must hold it until `req_ready`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - lh/lhu/sh with addr[0]≠0 is rejected with `resp_err`.
  - lw/sw with addr[1:0]≠0 is rejected with `resp_err`.
- `LSU_MISALIGN_TRAP_EN` undefined: misaligned accesses proceed normally, since the memory is byte-addressed and handles them correctly.

## Test plan
- sw 0x11223344 @0x10, then lw @0x10 → rdata 0x11223344. Store `resp_valid` 2 cycles and load `resp_valid` 3 cycles after accept; `mem_w` = 0x44332211.
- After the sw above, lb @0x10 → 0x00000044; lhu @0x12 → 0x00001122.
- sb 0x80 @0x13, then lb @0x13 → 0xFFFFFF80 and lbu @0x13 → 0x00000080; bytes @0x10–0x12 unchanged (lw → 0x80223344).
- M=10: lw @0xFFD → `resp_err`=1, rdata 0, 1-cycle latency, `mem_wf` never high. funct3=011 → `resp_err`.
- sw @0x21 with the macro defined → `resp_err`. Without the macro → lw @0x21 returns the written value.
- `resp_ready` low for 5 cycles → `resp_valid`/`resp_rdata` stable and `req_ready`=0. `rst_n` pulsed during ISSUE of a store → memory unchanged and all outputs at their reset values.

Source files
------------

// File: rtl/lsu.sv
// lsu: RISC-V load/store unit in front of a big-endian, byte-addressed memory with one-cycle registered read.
// Optional feature macro LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses.
module lsu #(
    parameter int M = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [31:0]  resp_rdata,
    output logic         resp_err,
    output logic [M+1:0] mem_address,
    output logic [31:0]  mem_mask,
    output logic         mem_wf,
    output logic [31:0]  mem_w,
    input  logic [31:0]  mem_v
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    // Highest byte address whose 4-byte memory access still fits.
    localparam logic [31:0] MAX_ADDR = 32'((64'd4 << M) - 64'd4);

    state_t       r_state;
    logic         r_req_ready;
    logic         r_resp_valid;
    logic         r_resp_err;
    logic [31:0]  r_resp_rdata;
    logic         r_we;
    logic [2:0]   r_funct3;
    logic [M+1:0] r_mem_address;
    logic [31:0]  r_mem_mask;
    logic         r_mem_wf;
    logic [31:0]  r_mem_w;

    logic         w_f3_ok;
    logic         w_misalign;
    logic         w_err;
    logic [31:0]  w_st_data;
    logic [31:0]  w_st_mask;
    logic [31:0]  w_lw_data;
    logic [31:0]  w_ld_data;

    always_comb begin
        w_f3_ok = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                         : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        w_misalign = 1'b0;
`endif
        w_err = !w_f3_ok || (req_addr > MAX_ADDR) || w_misalign;
    end

    // Register byte gi lives at ram[addr+gi], which the memory maps to lane 31-8*gi.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_st_data[31-8*gi -: 8] = req_wdata[8*gi +: 8];
        assign w_st_mask[31-8*gi -: 8] = (32'(gi) < (32'd1 << req_funct3[1:0])) ? 8'hFF : 8'h00;
        assign w_lw_data[8*gi +: 8]    = mem_v[31-8*gi -: 8];
    end

    always_comb begin
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_lw_data[7]}}, w_lw_data[7:0]};
            3'b001:  w_ld_data = {{16{w_lw_data[15]}}, w_lw_data[15:0]};
            3'b100:  w_ld_data = {24'h0, w_lw_data[7:0]};
            3'b101:  w_ld_data = {16'h0, w_lw_data[15:0]};
            default: w_ld_data = w_lw_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_err    <= 1'b0;
            r_resp_rdata  <= '0;
            r_we          <= 1'b0;
            r_funct3      <= '0;
            r_mem_address <= '0;
            r_mem_mask    <= '0;
            r_mem_wf      <= 1'b0;
            r_mem_w       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we          <= req_we;
                        r_funct3      <= req_funct3;
                        r_mem_address <= req_addr[M+1:0];
                        r_req_ready   <= 1'b0;
                        if (w_err) begin
                            r_mem_wf     <= 1'b0;
                            r_mem_mask   <= '0;
                            r_mem_w      <= '0;
                            r_resp_err   <= 1'b1;
                            r_resp_valid <= 1'b1;
                            r_state      <= RESP;
                        end else begin
                            r_mem_wf   <= req_we;
                            r_mem_mask <= req_we ? w_st_mask : '0;
                            r_mem_w    <= req_we ? (w_st_data & w_st_mask) : '0;
                            r_state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_mem_wf <= 1'b0;
                    if (r_we) begin
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_resp_rdata <= w_ld_data;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= '0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_err    = r_resp_err;
    assign resp_rdata  = r_resp_rdata;
    assign mem_address = r_mem_address;
    assign mem_mask    = r_mem_mask;
    assign mem_wf      = r_mem_wf;
    assign mem_w       = r_mem_w;
endmodule
